if_stage_pipe_reg: RTL and testbench
====================================

IF_STAGE_PIPE_REG -- requirements
Module: if_stage_pipe_reg

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, the width of the fetch PC field.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, the width of the instruction field.
REQ-003 SHALL have parameter NOP_INSTR, default 0 (INSTR_WIDTH bits), the instruction value driven while the output holds no valid beat.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-006 SHALL have port flush, input, 1, a synchronous discard of all held beats (branch redirect).
REQ-007 SHALL have port in_valid, input, 1, meaning the fetch stage offers a beat.
REQ-008 SHALL have port in_ready, output, 1, meaning this block accepts the offered beat this cycle.
REQ-009 SHALL have port in_pc, input, PC_WIDTH, the PC of the offered beat.
REQ-010 SHALL have port in_instr, input, INSTR_WIDTH, the instruction of the offered beat.
REQ-011 SHALL have port out_valid, output, 1, meaning the decode side is offered a beat.
REQ-012 SHALL have port out_ready, input, 1, meaning the decode side takes the offered beat.
REQ-013 SHALL have port out_pc, output, PC_WIDTH, the PC of the head beat.
REQ-014 SHALL have port out_instr, output, INSTR_WIDTH, the instruction of the head beat.

Function
REQ-015 SHALL define accept as in_valid & in_ready and take as out_valid & out_ready, both sampled at the clock edge.
REQ-016 SHALL deliver beats in acceptance order, with none lost or duplicated, except on flush or rst.
REQ-017 SHALL give a latency of 1 cycle: a beat accepted while empty appears on out_valid/out_pc/out_instr in the next cycle.
REQ-018 SHALL drive out_instr = NOP_INSTR and out_pc = 0 whenever out_valid = 0.
REQ-019 SHALL hold out_pc and out_instr stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL use states EMPTY (0 beats), ONE (1 beat in the main register) and TWO (main register plus skid register).
REQ-021 SHALL, in EMPTY, go to ONE on accept, with main loaded from the input; otherwise stay in EMPTY.
REQ-022 SHALL, in ONE, on accept with take, stay in ONE with main reloaded from the input.
REQ-023 SHALL, in ONE, on accept without take, go to TWO with the skid register loaded from the input.
REQ-024 SHALL, in ONE, on take without accept, go to EMPTY.
REQ-025 SHALL, in TWO, hold in_ready = 0, and on take go to ONE with main loaded from the skid register.
REQ-026 SHALL make flush take priority over accept and take: the next state is EMPTY, both registers are cleared, and any beat accepted in the flush cycle is discarded.
REQ-027 SHALL make a take occurring in the flush cycle count as delivered to the downstream stage; the block does not re-issue it.

Reset
REQ-028 SHALL, with rst = 1 at a clock edge, set the state to EMPTY, out_valid to 0, out_pc to 0 and out_instr to NOP_INSTR, and set in_ready to 1 in the following cycle.
REQ-029 SHALL give rst priority over flush, accept and take, including when rst is asserted mid-stream in state TWO.

Configuration
REQ-030 SHALL, with macro IF_STAGE_PIPE_REG_SKID_EN defined, implement the skid register and state TWO, and drive in_ready = (state != TWO) directly from a flop, with no combinational path from out_ready.
REQ-031 SHALL, with IF_STAGE_PIPE_REG_SKID_EN undefined, omit the skid register and state TWO, and drive in_ready = !out_valid | out_ready combinationally; all other requirements still apply.

Verification
REQ-032 SHALL be verified by this scenario: rst, then in_valid = 1 with pc = 0x100, instr = 0x00A00093, and out_ready = 1 -> next cycle out_valid = 1, out_pc = 0x100, out_instr = 0x00A00093.
REQ-033 SHALL be verified by this scenario: a stream of PCs 0x0, 0x4, 0x8 with out_ready low for 2 cycles (SKID_EN) -> in_ready drops after 2 accepts, and the output order is 0x0, 0x4, 0x8 with no loss.
REQ-034 SHALL be verified by this scenario: state TWO, flush = 1 with in_valid = 1 -> next cycle out_valid = 0, out_instr = NOP_INSTR, and no held beat is output afterwards.
REQ-035 SHALL be verified by this scenario: rst asserted in state TWO with out_ready = 0 -> next cycle out_valid = 0, out_pc = 0, in_ready = 1.
REQ-036 SHALL be verified by this scenario: SKID_EN undefined, out_valid = 1 and out_ready toggled -> in_ready follows out_ready in the same cycle, and throughput is 1 beat per cycle while out_ready = 1.
REQ-037 SHALL be verified by this scenario: in_valid = 1 and out_ready = 1 held for 100 cycles with incrementing PCs -> 100 beats delivered in order, with out_valid continuous after the first cycle.

Source files
------------

// File: rtl/if_stage_pipe_reg.sv
// IF->ID pipeline register with valid/ready handshake, flush and optional skid buffer.
// Define IF_STAGE_PIPE_REG_SKID_EN for a registered in_ready (adds the skid register and state TWO).
module if_stage_pipe_reg #(
  parameter int unsigned            PC_WIDTH    = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr
);

`ifdef IF_STAGE_PIPE_REG_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic [0:0] {EMPTY = 1'b0, ONE = 1'b1} state_t;
`endif

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   accept, take;

`ifdef IF_STAGE_PIPE_REG_SKID_EN
  logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
`else
  // Without a skid slot the register can only take a new beat if the current one leaves.
  assign in_ready = !out_valid | out_ready;
`endif

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // Next-state and next-data selection; out_pc/out_instr act as the main register.
  always_comb begin
    state_d = state_q;
    pc_d    = out_pc;
    instr_d = out_instr;
`ifdef IF_STAGE_PIPE_REG_SKID_EN
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      pc_d    = '0;
      instr_d = NOP_INSTR;
`ifdef IF_STAGE_PIPE_REG_SKID_EN
      skid_pc_d    = '0;
      skid_instr_d = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            pc_d    = in_pc;
            instr_d = in_instr;
          end
        end
        ONE: begin
          if (accept && take) begin
            pc_d    = in_pc;
            instr_d = in_instr;
          end else if (take) begin
            state_d = EMPTY;
            pc_d    = '0;
            instr_d = NOP_INSTR;
`ifdef IF_STAGE_PIPE_REG_SKID_EN
          end else if (accept) begin
            state_d      = TWO;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
`endif
          end
        end
`ifdef IF_STAGE_PIPE_REG_SKID_EN
        TWO: begin
          if (take) begin
            state_d      = ONE;
            pc_d         = skid_pc_q;
            instr_d      = skid_instr_q;
            skid_pc_d    = '0;
            skid_instr_d = '0;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          pc_d    = '0;
          instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= NOP_INSTR;
`ifdef IF_STAGE_PIPE_REG_SKID_EN
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      in_ready     <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != EMPTY);
      out_pc    <= pc_d;
      out_instr <= instr_d;
`ifdef IF_STAGE_PIPE_REG_SKID_EN
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      in_ready     <= (state_d != TWO);
`endif
    end
  end

endmodule

// File: tb/tb_if_stage_pipe_reg.sv
// Bench for if_stage_pipe_reg: directed scenarios plus random traffic against a queue model.
module tb_if_stage_pipe_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_STAGE_PIPE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 0;

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} beat_t;
  beat_t       mq[$];
  logic [31:0] dlv[$];

  if_stage_pipe_reg #(.PC_WIDTH(32), .INSTR_WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs against the model, advance model, cross the rising edge.
  task automatic tick();
    bit    exp_valid, exp_ready;
    beat_t head;
    #1;
    exp_valid = (mq.size() > 0);
    exp_ready = (mq.size() < CAP) || (CAP == 1 && out_ready);
    head      = exp_valid ? mq[0] : '{pc: 32'h0, instr: NOP};
    if (chk_en) begin
      cmp("out_valid", 64'(out_valid), 64'(exp_valid));
      cmp("out_pc",    64'(out_pc),    64'(head.pc));
      cmp("out_instr", 64'(out_instr), 64'(head.instr));
      cmp("in_ready",  64'(in_ready),  64'(exp_ready));
    end
    if (out_valid === 1'b1 && out_ready) dlv.push_back(out_pc);
    if (rst || flush) mq.delete();
    else begin
      if (exp_valid && out_ready) void'(mq.pop_front());
      if (in_valid && exp_ready) mq.push_back('{pc: in_pc, instr: in_instr});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_two();
    out_ready = 0; flush = 0; in_valid = 1;
    in_pc = 32'h200; in_instr = 32'hA1; tick();
    in_pc = 32'h204; in_instr = 32'hA2; tick();
    in_valid = 0;
  endtask

  initial begin
    logic [31:0] pcs [3];
    int          idx;
    bit          acc;

    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_instr = 0;
    tick();
    chk_en = 1;
    tick();
    #1;
    cmp("rst_valid", 64'(out_valid), 64'(0));
    cmp("rst_instr", 64'(out_instr), 64'(NOP));
    cmp("rst_ready", 64'(in_ready), 64'(1));
    rst = 0;

    // First beat appears one cycle after acceptance.
    in_valid = 1; in_pc = 32'h100; in_instr = 32'h00A0_0093; out_ready = 1;
    tick();
    in_valid = 0;
    #1;
    cmp("s1_valid", 64'(out_valid), 64'(1));
    cmp("s1_pc",    64'(out_pc),    64'(32'h100));
    cmp("s1_instr", 64'(out_instr), 64'(32'h00A0_0093));
    tick(); tick();

    // Stream 0x0,0x4,0x8 with downstream stalled for the first two cycles.
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    dlv.delete(); idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid  = (idx < 3);
      in_pc     = (idx < 3) ? pcs[idx] : 32'h0;
      in_instr  = 32'h1000 + 32'(idx);
      out_ready = (cyc >= 2);
      #1;
`ifdef IF_STAGE_PIPE_REG_SKID_EN
      if (cyc == 2) cmp("s2_ready_drop", 64'(in_ready), 64'(0));
`else
      if (cyc == 1) cmp("s2_ready_drop", 64'(in_ready), 64'(0));
`endif
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 0;
    cmp("s2_count", 64'(dlv.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      cmp("s2_order", 64'((i < dlv.size()) ? dlv[i] : 32'hFFFF_FFFF), 64'(pcs[i]));

    // Flush while full, with a beat offered in the same cycle.
    fill_two();
    flush = 1; in_valid = 1; in_pc = 32'h300; in_instr = 32'hBB;
    tick();
    flush = 0; in_valid = 0;
    #1;
    cmp("s3_valid", 64'(out_valid), 64'(0));
    cmp("s3_instr", 64'(out_instr), 64'(NOP));
    dlv.delete(); out_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    cmp("s3_no_stale", 64'(dlv.size()), 64'(0));

    // Reset while full and stalled.
    fill_two();
    rst = 1; in_valid = 1; in_pc = 32'h400;
    tick();
    rst = 0; in_valid = 0;
    #1;
    cmp("s4_valid", 64'(out_valid), 64'(0));
    cmp("s4_pc",    64'(out_pc),    64'(0));
    cmp("s4_ready", 64'(in_ready),  64'(1));
    tick();

    // Toggle out_ready with a held beat and continuous input.
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      in_pc = 32'h500 + 32'(4 * i); in_instr = 32'(i);
      out_ready = i[0];
      #1;
`ifndef IF_STAGE_PIPE_REG_SKID_EN
      if (out_valid === 1'b1) cmp("s5_ready_follows", 64'(in_ready), 64'(out_ready));
`endif
      tick();
    end
    in_valid = 0; out_ready = 1;
    tick(); tick(); tick();

    // 100 back-to-back beats.
    dlv.delete(); in_valid = 1; out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      in_pc = 32'h1_0000 + 32'(4 * i); in_instr = 32'h2_0000 + 32'(i);
      tick();
    end
    in_valid = 0;
    tick(); tick();
    cmp("s6_count", 64'(dlv.size()), 64'(100));
    idx = -1;
    for (int i = 0; i < dlv.size() && i < 100; i++)
      if (idx < 0 && dlv[i] != 32'h1_0000 + 32'(4 * i)) idx = i;
    cmp("s6_first_bad_idx", 64'(idx), 64'(-1));

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
